dmem_access_ctrl: RTL and testbench

- Sequencer and arbiter for the single-port data (variable) memory.
- Two requesters share the port:
  - CPU data port: load/store on a cache miss.
  - IO readback port: DIP-addressed display read.
- Models a fixed multi-cycle main-memory latency and returns a one-cycle ready pulse per completed access.
- Sits between the ARM core / IO logic and the DATA_VAR memory array; replaces the ad-hoc hit counter.

---
 rtl/dmem_access_ctrl.sv | 117 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Arbiter/sequencer for the single-port data memory: CPU vs IO readback, fixed LATENCY cycles
// from grant to a one-cycle ready pulse; requesters hold req until ready, the loser simply waits.
module dmem_access_ctrl #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int LATENCY     = 5,
    parameter int IO_MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic [ADDR_W-1:0] io_addr,
    output logic              io_ready,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_FIRE = 4'(LATENCY - 1);
    localparam logic [3:0] WAIT_MAX = 4'(IO_MAX_WAIT);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [3:0]        io_wait, io_wait_nxt;
    logic              owner_io;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              io_win;
    logic              fire;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            io_wait <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            io_wait <= io_wait_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        io_wait_nxt = io_wait;
        // IO only beats a requesting CPU once it has been passed over IO_MAX_WAIT times
        io_win      = io_req && (!cpu_req || io_wait == WAIT_MAX);
        fire        = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req || io_req) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'd1;
                    if (io_win)
                        io_wait_nxt = '0;
                    else if (io_req && io_wait != WAIT_MAX)
                        io_wait_nxt = io_wait + 4'd1;
                end
            end
            BUSY: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == CNT_FIRE) begin
                    fire      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        mem_en    = fire;
        mem_we    = fire && lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        cpu_ready = (state == DONE) && !owner_io;
        io_ready  = (state == DONE) && owner_io;
        busy      = (state != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            owner_io  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cpu_rdata <= '0;
            io_rdata  <= '0;
        end else begin
            if (state == IDLE && (cpu_req || io_req)) begin
                owner_io  <= io_win;
                lat_we    <= io_win ? 1'b0 : cpu_we;
                lat_addr  <= io_win ? io_addr : cpu_addr;
                lat_wdata <= io_win ? '0 : cpu_wdata;
            end
            // write completions leave the owner's read register untouched
            if (fire && !lat_we) begin
                if (owner_io)
                    io_rdata <= mem_rdata;
                else
                    cpu_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table, directed multi-cycle sequences, random batches vs a transaction model.
module tb_dmem_access_ctrl;
    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int L    = 5;
    localparam int MAXW = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          io_req = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic          io_ready;
    logic [DW-1:0] io_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    always #5 CLK = ~CLK;

    dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L), .IO_MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_addr(io_addr), .io_ready(io_ready), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [DW-1:0] mem     [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct { bit io; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } op_t;
    typedef struct { bit io; int cyc; logic [DW-1:0] rd; } ev_t;
    typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } en_t;
    typedef struct { op_t op; logic [DW-1:0] exp_rd; } vec_t;

    op_t cq[$];
    op_t iq[$];
    ev_t ev_q[$];
    ev_t xq[$];
    en_t en_q[$];
    vec_t tbl[9];

    int total = 0;
    int bad = 0;
    int m_wait = 0;
    logic [DW-1:0] m_cpu_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic op_t mkop(input bit io, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.io = io; o.we = we; o.addr = a; o.wdata = d;
        return o;
    endfunction

    function automatic vec_t mkvec(input bit io, input bit we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input logic [DW-1:0] e);
        vec_t v;
        v.op = mkop(io, we, a, d); v.exp_rd = e;
        return v;
    endfunction

    task automatic drive(input int ci, input int ii);
        cpu_req = (ci < cq.size());
        if (ci < cq.size()) begin
            cpu_we = cq[ci].we; cpu_addr = cq[ci].addr; cpu_wdata = cq[ci].wdata;
        end else begin
            cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        end
        io_req  = (ii < iq.size());
        io_addr = (ii < iq.size()) ? iq[ii].addr : '0;
    endtask

    // Each requester holds its current op until its ready, then presents the next one at once.
    task automatic run_batch(input int bound);
        int ci, ii, k;
        ev_t e;
        en_t n;
        ci = 0; ii = 0; k = 0;
        ev_q.delete(); en_q.delete();
        @(negedge CLK);
        drive(ci, ii);
        while ((ci < cq.size() || ii < iq.size()) && k < bound) begin
            @(negedge CLK);
            k++;
            if (mem_en) begin
                n.cyc = k; n.we = mem_we; n.addr = mem_addr; n.wdata = mem_wdata;
                en_q.push_back(n);
            end
            if (cpu_ready) begin
                e.io = 1'b0; e.cyc = k; e.rd = cpu_rdata; ev_q.push_back(e); ci++;
            end
            if (io_ready) begin
                e.io = 1'b1; e.cyc = k; e.rd = io_rdata; ev_q.push_back(e); ii++;
            end
            drive(ci, ii);
        end
        if (ci < cq.size() || ii < iq.size()) begin
            total++; bad++;
            $display("FAIL batch_timeout: got cpu=%0d io=%0d done want cpu=%0d io=%0d", ci, ii, cq.size(), iq.size());
        end
        cpu_req = 1'b0; io_req = 1'b0;
    endtask

    // Transaction-level prediction: grant order, ready cycle and returned data per access.
    task automatic predict(output int span);
        int ci, ii, t;
        bit iow;
        ev_t e;
        ci = 0; ii = 0; t = 0;
        xq.delete();
        while (ci < cq.size() || ii < iq.size()) begin
            iow = (ii < iq.size()) && (ci >= cq.size() || m_wait == MAXW);
            e.io = iow; e.cyc = t + L;
            if (iow) begin
                e.rd = ref_mem[iq[ii].addr]; m_wait = 0; ii++;
            end else begin
                if (ii < iq.size() && m_wait < MAXW) m_wait++;
                if (cq[ci].we) ref_mem[cq[ci].addr] = cq[ci].wdata;
                else m_cpu_rd = ref_mem[cq[ci].addr];
                e.rd = m_cpu_rd; ci++;
            end
            xq.push_back(e);
            t = t + L + 1;
        end
        span = t;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, nrdy, rcyc, nen, span, j;
        logic [DW-1:0] rd;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end

        // reset and idle
        repeat (3) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        RESET = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (mem_en || mem_we || busy || cpu_ready || io_ready) n++;
        end
        check("idle_quiet", n, 0);
        check("idle_cpu_rdata", cpu_rdata, 0);
        check("idle_io_rdata", io_rdata, 0);
        check("idle_mem_addr", mem_addr, 0);
        check("idle_mem_wdata", mem_wdata, 0);

        // single-access vectors (memory preloaded with A500_0000|addr)
        tbl[0] = mkvec(0, 1, 11'h004, 32'h0000_000B, 32'h0000_0000);
        tbl[1] = mkvec(0, 0, 11'h004, 32'h0,         32'h0000_000B);
        tbl[2] = mkvec(0, 1, 11'h7FF, 32'h1234_5678, 32'h0000_000B);
        tbl[3] = mkvec(1, 0, 11'h7FF, 32'h0,         32'h1234_5678);
        tbl[4] = mkvec(0, 0, 11'h000, 32'h0,         32'hA500_0000);
        tbl[5] = mkvec(1, 0, 11'h004, 32'h0,         32'h0000_000B);
        tbl[6] = mkvec(0, 1, 11'h000, 32'hCAFE_F00D, 32'hA500_0000);
        tbl[7] = mkvec(0, 0, 11'h000, 32'h0,         32'hCAFE_F00D);
        tbl[8] = mkvec(1, 0, 11'h3FF, 32'h0,         32'hA500_03FF);
        for (int i = 0; i < 9; i++) begin
            cq.delete(); iq.delete();
            if (tbl[i].op.io) iq.push_back(tbl[i].op); else cq.push_back(tbl[i].op);
            run_batch(30);
            check($sformatf("vec%0d_nready", i), ev_q.size(), 1);
            if (ev_q.size() == 1) begin
                check($sformatf("vec%0d_port", i), ev_q[0].io, tbl[i].op.io);
                check($sformatf("vec%0d_lat", i), ev_q[0].cyc, L);
                check($sformatf("vec%0d_rdata", i), ev_q[0].rd, tbl[i].exp_rd);
            end
            check($sformatf("vec%0d_nen", i), en_q.size(), 1);
            if (en_q.size() == 1) begin
                check($sformatf("vec%0d_en_cyc", i), en_q[0].cyc, L - 1);
                check($sformatf("vec%0d_we", i), en_q[0].we, tbl[i].op.we);
                check($sformatf("vec%0d_addr", i), en_q[0].addr, tbl[i].op.addr);
                if (tbl[i].op.we) check($sformatf("vec%0d_wdata", i), en_q[0].wdata, tbl[i].op.wdata);
            end
            if (tbl[i].op.we) ref_mem[tbl[i].op.addr] = tbl[i].op.wdata;
        end
        m_cpu_rd = 32'hCAFE_F00D;

        // contention: CPU first, IO right after
        cq.delete(); iq.delete();
        cq.push_back(mkop(0, 0, 11'h7FF, 0));
        iq.push_back(mkop(1, 0, 11'h004, 0));
        run_batch(40);
        check("cont_nready", ev_q.size(), 2);
        if (ev_q.size() == 2) begin
            check("cont_first_port", ev_q[0].io, 0);
            check("cont_first_cyc", ev_q[0].cyc, L);
            check("cont_cpu_rdata", ev_q[0].rd, 32'h1234_5678);
            check("cont_second_port", ev_q[1].io, 1);
            check("cont_second_cyc", ev_q[1].cyc, 2 * L + 1);
            check("cont_io_rdata", ev_q[1].rd, 32'h0000_000B);
        end
        m_cpu_rd = 32'h1234_5678;

        // starvation bound: CPU held continuously, IO wins after exactly MAXW CPU grants, twice
        cq.delete(); iq.delete();
        for (int i = 0; i < 9; i++) cq.push_back(mkop(0, 0, 11'(i), 0));
        for (int i = 0; i < 2; i++) iq.push_back(mkop(1, 0, 11'h7FF, 0));
        run_batch(100);
        check("starve_nready", ev_q.size(), 11);
        j = 0;
        for (int i = 0; i < ev_q.size() && i < 11; i++) begin
            check($sformatf("starve%0d_port", i), ev_q[i].io, (i == 4 || i == 9));
            check($sformatf("starve%0d_cyc", i), ev_q[i].cyc, i * (L + 1) + L);
            if (i == 4 || i == 9) check($sformatf("starve%0d_rd", i), ev_q[i].rd, ref_mem[11'h7FF]);
            else begin
                check($sformatf("starve%0d_rd", i), ev_q[i].rd, ref_mem[j]);
                j++;
            end
        end
        m_cpu_rd = ref_mem[8];

        // request dropped mid-access still completes exactly once
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h004;
        nrdy = 0; rcyc = -1; nen = 0; rd = '0;
        for (k = 1; k <= 15; k++) begin
            @(negedge CLK);
            if (mem_en) nen++;
            if (cpu_ready) begin nrdy++; rcyc = k; rd = cpu_rdata; end
            if (k == 2) begin cpu_req = 1'b0; cpu_addr = 11'h7FF; end
        end
        check("drop_nready", nrdy, 1);
        check("drop_cyc", rcyc, L);
        check("drop_rdata", rd, 32'h0000_000B);
        check("drop_nen", nen, 1);
        check("drop_idle", busy, 0);

        // reset in the middle of a write
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_cpu_rdata", cpu_rdata, 0);
        nen = 0; nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 2) RESET = 1'b1;
            if (mem_en) nen++;
            if (cpu_ready || io_ready) nrdy++;
        end
        check("rstmid_nen", nen, 0);
        check("rstmid_nready", nrdy, 0);
        check("rstmid_mem", mem[11'h010], ref_mem[11'h010]);
        check("rstmid_idle", busy, 0);
        m_cpu_rd = '0;
        m_wait = 0;

        // random batches against the transaction model
        for (int b = 0; b < 30; b++) begin
            int nc, ni;
            cq.delete(); iq.delete();
            nc = $urandom_range(0, 5);
            ni = $urandom_range(0, 2);
            if (nc == 0 && ni == 0) nc = 1;
            for (int i = 0; i < nc; i++)
                cq.push_back(mkop(0, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), $urandom));
            for (int i = 0; i < ni; i++)
                iq.push_back(mkop(1, 0, 11'($urandom_range(0, 15)), 0));
            predict(span);
            run_batch(span + 20);
            check($sformatf("rnd%0d_nready", b), ev_q.size(), xq.size());
            for (int i = 0; i < ev_q.size() && i < xq.size(); i++) begin
                check($sformatf("rnd%0d_%0d_port", b, i), ev_q[i].io, xq[i].io);
                check($sformatf("rnd%0d_%0d_cyc", b, i), ev_q[i].cyc, xq[i].cyc);
                check($sformatf("rnd%0d_%0d_rd", b, i), ev_q[i].rd, xq[i].rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
